// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port Data_memory: round-robin per beat,
// optional locked bursts capped at BURST_MAX, registered read response.
// Define DMEM_ARB_FIXED_PRIO_EN to give port 0 strict priority instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  localparam int CNT_W = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  typedef enum logic [1:0] {
    LOCK_NONE,
    LOCK_P0,
    LOCK_P1
  } lock_t;

  lock_t            lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= LOCK_NONE;
      cnt_q  <= '0;
      last_q <= 1'b1;
    end else begin
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  // Any beat that does not extend a lock (unlocked grant, idle, owner gone) clears the burst.
  always_comb begin
    lock_d = LOCK_NONE;
    cnt_d  = '0;
    last_d = last_q;
    if (m0_gnt) begin
      last_d = 1'b0;
      if (m0_lock) begin
        lock_d = LOCK_P0;
        if (lock_q == LOCK_P0)
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        else
          cnt_d = CNT_W'(1);
      end
    end else if (m1_gnt) begin
      last_d = 1'b1;
      if (m1_lock) begin
        lock_d = LOCK_P1;
        if (lock_q == LOCK_P1)
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        else
          cnt_d = CNT_W'(1);
      end
    end
  end

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      if (m0_req)
        m0_gnt = 1'b1;
      else if (m1_req)
        m1_gnt = 1'b1;
`else
      if (lock_q == LOCK_P0 && m0_req) begin
        if (cnt_q == CNT_MAX && m1_req) m1_gnt = 1'b1;
        else                            m0_gnt = 1'b1;
      end else if (lock_q == LOCK_P1 && m1_req) begin
        if (cnt_q == CNT_MAX && m0_req) m0_gnt = 1'b1;
        else                            m1_gnt = 1'b1;
      end else if (m0_req && m1_req) begin
        if (last_q) m0_gnt = 1'b1;
        else        m1_gnt = 1'b1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
`endif
    end
    mem_A  = '0;
    mem_WD = '0;
    mem_WE = 1'b0;
    if (m0_gnt) begin
      mem_A  = m0_addr;
      mem_WD = m0_wdata;
      mem_WE = m0_we;
    end else if (m1_gnt) begin
      mem_A  = m1_addr;
      mem_WD = m1_wdata;
      mem_WE = m1_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_RD;
      if (m1_gnt && !m1_we) m1_rdata <= mem_RD;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration rules and a shadow memory.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD, mem_RD;
  logic          mem_WE;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  // Stand-in for Data_memory: combinational read, write on the rising edge.
  logic [DW-1:0] mem [16];
  assign mem_RD = mem[mem_A[3:0]];
  always @(posedge clk) if (mem_WE) mem[mem_A[3:0]] <= mem_WD;

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = AW'(7); m0_wdata = 32'h1234;
    m1_req = 1'b1;
    #3;
    n_cmp++;
    if ({m0_gnt, m1_gnt, mem_WE} !== 3'b000) begin
      n_err++; $display("FAIL rst_gnt: gnt0,gnt1,we=%b expected 000", {m0_gnt, m1_gnt, mem_WE});
    end
    n_cmp++;
    if (mem_A !== '0 || mem_WD !== '0) begin
      n_err++; $display("FAIL rst_bus: A=%h WD=%h expected 0/0", mem_A, mem_WD);
    end
    tick();
    tick();
    n_cmp++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== '0 || m1_rdata !== '0) begin
      n_err++; $display("FAIL rst_resp: rv=%b rd0=%h rd1=%h expected 00/0/0",
                        {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
    end
    idle();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #3;
      n_cmp++;
      if ({m0_gnt, m1_gnt, mem_WE} !== 3'b000) begin
        n_err++; $display("FAIL idle_gnt: gnt0,gnt1,we=%b expected 000", {m0_gnt, m1_gnt, mem_WE});
      end
      tick();
      n_cmp++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== '0 || m1_rdata !== '0) begin
        n_err++; $display("FAIL idle_resp: rv=%b rd0=%h rd1=%h expected 00/0/0",
                          {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
      end
    end
  endtask

  task automatic test_write_read();
    idle();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = AW'(3); m0_wdata = 32'h55;
    #3;
    n_cmp++;
    if ({m0_gnt, m1_gnt, mem_WE} !== 3'b101 || mem_A !== AW'(3) || mem_WD !== 32'h55) begin
      n_err++; $display("FAIL wr_beat: gnt0,gnt1,we=%b A=%h WD=%h expected 101/3/55",
                        {m0_gnt, m1_gnt, mem_WE}, mem_A, mem_WD);
    end
    tick();
    idle();
    m1_req = 1'b1; m1_addr = AW'(3);
    n_cmp++;
    if (m0_rvalid !== 1'b0) begin
      n_err++; $display("FAIL wr_no_resp: m0_rvalid=%b expected 0", m0_rvalid);
    end
    #3;
    n_cmp++;
    if ({m0_gnt, m1_gnt, mem_WE} !== 3'b010) begin
      n_err++; $display("FAIL rd_beat: gnt0,gnt1,we=%b expected 010", {m0_gnt, m1_gnt, mem_WE});
    end
    tick();
    idle();
    n_cmp++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h55) begin
      n_err++; $display("FAIL rd_resp: m1_rvalid=%b m1_rdata=%h expected 1/55", m1_rvalid, m1_rdata);
    end
    tick();
    n_cmp++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h55) begin
      n_err++; $display("FAIL rd_hold: m1_rvalid=%b m1_rdata=%h expected 0/55", m1_rvalid, m1_rdata);
    end
  endtask

`ifndef DMEM_ARB_FIXED_PRIO_EN
  task automatic test_round_robin();
    idle();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = AW'(5); m1_wdata = 32'hAA;
    tick();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      m0_req = 1'b1; m0_addr = AW'(3);
      m1_req = 1'b1; m1_addr = AW'(5);
      #3;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL rr_gnt[%0d]: gnt0,gnt1=%b expected %b", i, {m0_gnt, m1_gnt},
                          (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      tick();
      n_cmp++;
      if ({m0_rvalid, m1_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01) ||
          ((i % 2 == 0) ? m0_rdata : m1_rdata) !== ((i % 2 == 0) ? 32'h55 : 32'hAA)) begin
        n_err++; $display("FAIL rr_resp[%0d]: rv=%b rd0=%h rd1=%h", i, {m0_rvalid, m1_rvalid},
                          m0_rdata, m1_rdata);
      end
    end
    idle();
  endtask

  task automatic test_burst_lock();
    int  k;
    bit  m0_done;
    logic [1:0] exp;
    idle();
    for (int i = 0; i < 8; i++) begin
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = AW'(i); m0_wdata = 32'h100 + DW'(i);
      #3;
      n_cmp++;
      if (m0_gnt !== 1'b1) begin
        n_err++; $display("FAIL preload_gnt[%0d]: m0_gnt=%b expected 1", i, m0_gnt);
      end
      tick();
    end
    do_reset();
    k = 0;
    m0_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b0; m1_addr = AW'(k);
      m0_req = (c >= 1) && !m0_done; m0_we = 1'b0; m0_addr = AW'(3);
      exp = (c == 4) ? 2'b10 : 2'b01;
      #3;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== exp) begin
        n_err++; $display("FAIL burst_gnt[%0d]: gnt0,gnt1=%b expected %b", c, {m0_gnt, m1_gnt}, exp);
      end
      tick();
      n_cmp++;
      if (exp == 2'b01) begin
        if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h100 + DW'(k)) begin
          n_err++; $display("FAIL burst_rd1[%0d]: rv=%b rd=%h expected 1/%h", c, m1_rvalid,
                            m1_rdata, 32'h100 + DW'(k));
        end
        k++;
      end else begin
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h103) begin
          n_err++; $display("FAIL burst_rd0[%0d]: rv=%b rd=%h expected 1/103", c, m0_rvalid, m0_rdata);
        end
        m0_done = 1'b1;
      end
    end
    idle();
  endtask
`endif

  task automatic test_reset_mid_read();
    idle();
    m0_req = 1'b1; m0_addr = AW'(3);
    #3;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_err++; $display("FAIL mid_pre_gnt: gnt0,gnt1=%b expected 10", {m0_gnt, m1_gnt});
    end
    tick();
    rst = 1'b1;
    m1_req = 1'b1; m1_addr = AW'(3);
    #3;
    n_cmp++;
    if ({m0_gnt, m1_gnt, mem_WE} !== 3'b000 || mem_A !== '0 || m0_rvalid !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_cycle: gnt0,gnt1,we=%b A=%h rv0=%b expected 000/0/1",
                        {m0_gnt, m1_gnt, mem_WE}, mem_A, m0_rvalid);
    end
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== '0 || m1_rdata !== '0) begin
      n_err++; $display("FAIL mid_rst_resp: rv=%b rd0=%h rd1=%h expected 00/0/0",
                        {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
    end
    #3;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_err++; $display("FAIL mid_tie: gnt0,gnt1=%b expected 10", {m0_gnt, m1_gnt});
    end
    tick();
    idle();
    n_cmp++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'h103) begin
      n_err++; $display("FAIL mid_after: rv=%b rd0=%h expected 10/103", {m0_rvalid, m1_rvalid}, m0_rdata);
    end
  endtask

`ifdef DMEM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      m0_req = 1'b1; m0_addr = AW'(3); m1_req = 1'b1; m1_lock = 1'b1; m1_addr = AW'(5);
      #3;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
        n_err++; $display("FAIL fp_gnt[%0d]: gnt0,gnt1=%b expected 10", c, {m0_gnt, m1_gnt});
      end
      tick();
    end
    m0_req = 1'b0;
    #3;
    n_cmp++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      n_err++; $display("FAIL fp_release: gnt0,gnt1=%b expected 01", {m0_gnt, m1_gnt});
    end
    tick();
    idle();
  endtask
`endif

  // Reference: owner / burst count / last winner as plain integers, memory as an array.
  task automatic test_random();
    logic [DW-1:0] shadow [16];
    logic [DW-1:0] e_rd0, e_rd1;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;
    bit   e_rv0, e_rv1, e_we, lk, p0, p1;
    int   g, lw, own, cnt;
    do_reset();
    lw = 1; own = -1; cnt = 0;
    e_rd0 = '0; e_rd1 = '0;
    p0 = 1'b0; p1 = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = mem[i];
    for (int c = 0; c < 400; c++) begin
      if (!p0) begin
        m0_req = ($urandom_range(3) != 0); m0_we = 1'($urandom_range(1));
        m0_lock = ($urandom_range(2) != 0); m0_addr = AW'($urandom_range(15)); m0_wdata = $urandom;
      end
      if (!p1) begin
        m1_req = ($urandom_range(3) != 0); m1_we = 1'($urandom_range(1));
        m1_lock = ($urandom_range(2) != 0); m1_addr = AW'($urandom_range(15)); m1_wdata = $urandom;
      end
      p0 = m0_req; p1 = m1_req;
      g = -1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      if (m0_req) g = 0;
      else if (m1_req) g = 1;
`else
      if (own == 0 && m0_req)      g = (cnt == BM && m1_req) ? 1 : 0;
      else if (own == 1 && m1_req) g = (cnt == BM && m0_req) ? 0 : 1;
      else if (m0_req && m1_req)   g = 1 - lw;
      else if (m0_req)             g = 0;
      else if (m1_req)             g = 1;
`endif
      e_we = (g == 0) ? m0_we : (g == 1) ? m1_we : 1'b0;
      e_a  = (g == 0) ? m0_addr : (g == 1) ? m1_addr : '0;
      e_wd = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : '0;
      #3;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== {g == 0, g == 1}) begin
        n_err++; $display("FAIL rnd_gnt[%0d]: gnt0,gnt1=%b expected %b", c, {m0_gnt, m1_gnt},
                          {g == 0, g == 1});
      end
      n_cmp++;
      if (mem_WE !== e_we || mem_A !== e_a || mem_WD !== e_wd) begin
        n_err++; $display("FAIL rnd_bus[%0d]: we=%b A=%h WD=%h expected %b/%h/%h", c, mem_WE,
                          mem_A, mem_WD, e_we, e_a, e_wd);
      end
      e_rv0 = (g == 0) && !m0_we;
      e_rv1 = (g == 1) && !m1_we;
      if (e_rv0) e_rd0 = shadow[m0_addr[3:0]];
      if (e_rv1) e_rd1 = shadow[m1_addr[3:0]];
      if (g >= 0 && e_we) shadow[e_a[3:0]] = e_wd;
      lk = (g == 0) ? m0_lock : (g == 1) ? m1_lock : 1'b0;
      if (g >= 0) lw = g;
      if (lk) begin
        cnt = (own == g) ? ((cnt < BM) ? cnt + 1 : BM) : 1;
        own = g;
      end else begin
        own = -1; cnt = 0;
      end
      if (g == 0) p0 = 1'b0;
      if (g == 1) p1 = 1'b0;
      tick();
      n_cmp++;
      if ({m0_rvalid, m1_rvalid} !== {e_rv0, e_rv1} || m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
        n_err++; $display("FAIL rnd_resp[%0d]: rv=%b rd0=%h rd1=%h expected %b/%h/%h", c,
                          {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, {e_rv0, e_rv1}, e_rd0, e_rd1);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_write_read();
`ifndef DMEM_ARB_FIXED_PRIO_EN
    test_round_robin();
    test_burst_lock();
    test_reset_mid_read();
`else
    test_fixed_prio();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
